// File: rtl/axis_packet_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: defaults, state encoding
// and where the packet/beat indices sit inside each data beat.
package axis_packet_gen_pkg;

    localparam int DATA_WIDTH_DEFAULT = 512;
    localparam logic [7:0] FILL_BYTE = 8'hA5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int PKT_IDX_LSB    = 0;
    localparam int PKT_IDX_WIDTH  = 64;
    localparam int BEAT_IDX_LSB   = PKT_IDX_LSB + PKT_IDX_WIDTH;
    localparam int BEAT_IDX_WIDTH = 8;
    // First bit of the constant fill region; the region always starts on a byte boundary.
    localparam int FILL_LSB       = BEAT_IDX_LSB + BEAT_IDX_WIDTH;

endpackage

// File: rtl/axis_packet_gen_if.sv
// AXI-Stream bundle between the packet generator and the framing path.
interface axis_packet_gen_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_packet_gen.sv
// Single-channel AXI-Stream traffic source: on start, emits count packets of
// packet_length beats back-to-back, honouring downstream backpressure.
//
// state | meaning
// IDLE  | waiting for an accepted start; outputs quiet, packets_sent holds last result
// SEND  | streaming beats; advances only on tvalid && tready
module axis_packet_gen
    import axis_packet_gen_pkg::*;
#(
    parameter int         DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic [7:0] FILL_BYTE  = axis_packet_gen_pkg::FILL_BYTE
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [63:0]               count,
    input  logic [7:0]                packet_length,
    axis_packet_gen_if.master         axis,
    output logic                      busy,
    output logic [63:0]               packets_sent
);

    state_t                      state;
    logic [PKT_IDX_WIDTH-1:0]    pkts_total;
    logic [PKT_IDX_WIDTH-1:0]    pkt_idx;
    logic [BEAT_IDX_WIDTH-1:0]   beats_total;
    logic [BEAT_IDX_WIDTH-1:0]   beat_idx;
    logic                        tvalid_r;
    logic                        tlast_r;
    logic [DATA_WIDTH-1:0]       beat;
    logic                        xfer;

    assign xfer = tvalid_r && axis.tready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            pkts_total   <= '0;
            pkt_idx      <= '0;
            beats_total  <= '0;
            beat_idx     <= '0;
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            busy         <= 1'b0;
            packets_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != 64'd0) && (packet_length != 8'd0)) begin
                        state        <= SEND;
                        pkts_total   <= count;
                        beats_total  <= packet_length;
                        pkt_idx      <= '0;
                        beat_idx     <= '0;
                        packets_sent <= '0;
                        busy         <= 1'b1;
                        tvalid_r     <= 1'b1;
                        tlast_r      <= (packet_length == 8'd1);
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (tlast_r) begin
                            packets_sent <= packets_sent + 64'd1;
                            beat_idx     <= '0;
                            if (pkt_idx == pkts_total - 64'd1) begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                tvalid_r <= 1'b0;
                                tlast_r  <= 1'b0;
                            end else begin
                                pkt_idx  <= pkt_idx + 64'd1;
                                tlast_r  <= (beats_total == 8'd1);
                            end
                        end else begin
                            // Next beat is the last one when beat_idx+1 == beats_total-1.
                            beat_idx <= beat_idx + 8'd1;
                            tlast_r  <= ((beat_idx + 8'd2) == beats_total);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                end
            endcase
        end
    end

    // Data is derived from the registered indices, so it is stable while stalled.
    always_comb begin
        beat = '0;
        if (tvalid_r) begin
            for (int b = FILL_LSB / 8; b < DATA_WIDTH / 8; b++) begin
                beat[b*8 +: 8] = FILL_BYTE;
            end
            beat[PKT_IDX_LSB +: PKT_IDX_WIDTH]   = pkt_idx;
            beat[BEAT_IDX_LSB +: BEAT_IDX_WIDTH] = beat_idx;
        end
    end

    assign axis.tdata  = beat;
    assign axis.tvalid = tvalid_r;
    assign axis.tlast  = tlast_r;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed self-checking bench for axis_packet_gen.
module tb_axis_packet_gen;

    localparam int DW = 512;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [63:0] count;
    logic [7:0]  packet_length;
    logic        busy;
    logic [63:0] packets_sent;

    int checks = 0;
    int errors = 0;

    axis_packet_gen_if #(.DATA_WIDTH(DW)) axis ();

    axis_packet_gen #(.DATA_WIDTH(DW), .FILL_BYTE(8'hA5)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .count         (count),
        .packet_length (packet_length),
        .axis          (axis.master),
        .busy          (busy),
        .packets_sent  (packets_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] exp_beat(input logic [63:0] p, input logic [7:0] b);
        exp_beat = {{55{8'hA5}}, b, p};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [63:0] c, input logic [7:0] l);
        start = 1'b1;
        count = c;
        packet_length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] p, input logic [7:0] b, input logic last);
        chk({tag, "_tvalid"}, DW'(axis.tvalid), DW'(1'b1));
        chk({tag, "_tdata"}, axis.tdata, exp_beat(p, b));
        chk({tag, "_tlast"}, DW'(axis.tlast), DW'(last));
        chk({tag, "_busy"}, DW'(busy), DW'(1'b1));
    endtask

    task automatic chk_idle(input string tag, input logic [63:0] sent);
        chk({tag, "_tvalid"}, DW'(axis.tvalid), DW'(1'b0));
        chk({tag, "_busy"}, DW'(busy), DW'(1'b0));
        chk({tag, "_sent"}, DW'(packets_sent), DW'(sent));
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        count = '0;
        packet_length = '0;
        axis.tready = 1'b0;
        repeat (3) @(negedge clk);

        chk_idle("reset", 64'd0);
        chk("reset_tlast", DW'(axis.tlast), DW'(1'b0));
        chk("reset_tdata", axis.tdata, '0);
        resetn = 1'b1;
        @(negedge clk);

        // 3 packets x 4 beats, no backpressure
        axis.tready = 1'b1;
        pulse_start(64'd3, 8'd4);
        for (int i = 0; i < 12; i++) begin
            chk_beat($sformatf("t1_b%0d", i), 64'(i / 4), 8'(i % 4), (i % 4) == 3);
            @(negedge clk);
        end
        chk_idle("t1_end", 64'd3);

        // 2 packets x 1 beat, tready toggling
        axis.tready = 1'b1;
        pulse_start(64'd2, 8'd1);
        chk_beat("t2_p0", 64'd0, 8'd0, 1'b1);
        axis.tready = 1'b0;
        @(negedge clk);
        chk_beat("t2_p0_hold", 64'd0, 8'd0, 1'b1);
        axis.tready = 1'b1;
        @(negedge clk);
        chk_beat("t2_p1", 64'd1, 8'd0, 1'b1);
        axis.tready = 1'b0;
        @(negedge clk);
        chk_beat("t2_p1_hold", 64'd1, 8'd0, 1'b1);
        chk("t2_sent_mid", DW'(packets_sent), DW'(64'd1));
        axis.tready = 1'b1;
        @(negedge clk);
        chk_idle("t2_end", 64'd2);

        // rejected starts
        pulse_start(64'd0, 8'd5);
        chk_idle("t3_cnt0", 64'd2);
        pulse_start(64'd3, 8'd0);
        chk_idle("t3_len0", 64'd2);

        // 5 x 8 with a spurious start during packet 1
        axis.tready = 1'b1;
        pulse_start(64'd5, 8'd8);
        for (int i = 0; i < 40; i++) begin
            chk_beat($sformatf("t4_b%0d", i), 64'(i / 8), 8'(i % 8), (i % 8) == 7);
            start = (i == 10);
            count = (i == 10) ? 64'd1 : 64'd5;
            packet_length = (i == 10) ? 8'd2 : 8'd8;
            @(negedge clk);
            start = 1'b0;
        end
        chk_idle("t4_end", 64'd5);

        // reset mid-packet
        pulse_start(64'd2, 8'd4);
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("t5_b%0d", i), 64'd0, 8'(i), 1'b0);
            @(negedge clk);
        end
        chk_beat("t5_b3", 64'd0, 8'd3, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk_idle("t5_rst", 64'd0);
        chk("t5_rst_tlast", DW'(axis.tlast), DW'(1'b0));
        chk("t5_rst_tdata", axis.tdata, '0);
        pulse_start(64'd1, 8'd2);
        chk_beat("t5_n0", 64'd0, 8'd0, 1'b0);
        @(negedge clk);
        chk_beat("t5_n1", 64'd0, 8'd1, 1'b1);
        @(negedge clk);
        chk_idle("t5_end", 64'd1);

        // 64-bit count: truncated compare would stop at pkt_idx 1
        axis.tready = 1'b1;
        pulse_start(64'h1_0000_0002, 8'd1);
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("t6_b%0d", i), 64'(i), 8'd0, 1'b1);
            @(negedge clk);
        end
        chk_beat("t6_b3", 64'd3, 8'd0, 1'b1);
        axis.tready = 1'b0;
        force dut.pkt_idx = 64'hFFFF_FFFF;
        #1;
        release dut.pkt_idx;
        @(negedge clk);
        chk_beat("t6_force", 64'hFFFF_FFFF, 8'd0, 1'b1);
        axis.tready = 1'b1;
        @(negedge clk);
        chk_beat("t6_hi0", 64'h1_0000_0000, 8'd0, 1'b1);
        @(negedge clk);
        chk_beat("t6_hi1", 64'h1_0000_0001, 8'd0, 1'b1);
        @(negedge clk);
        chk_idle("t6_end", 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
